// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: word width, FC fan-in, pooling FSM
// states and the signed max / ReLU helpers.
package cnn_pkg;
   localparam int DATA_W = 32;
   localparam int FC_N   = 9;

   typedef enum logic {FILL, HOLD} state_t;

   function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                     input logic signed [DATA_W-1:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? '0 : x;
   endfunction
endpackage

// File: rtl/maxpool_flatten_if.sv
// Pixel stream in, pooled vector out: the handshake bundle between conv, pool and FC.
interface maxpool_flatten_if #(
   parameter int DATA_W = 32,
   parameter int OUT_N  = 9
);
   logic                     in_valid;
   logic                     in_ready;
   logic signed [DATA_W-1:0] in_pixel;
   logic                     vec_valid;
   logic                     vec_ack;
   logic [OUT_N*DATA_W-1:0]  out_vec;
   logic                     done;

   modport master (output in_valid, in_pixel, vec_ack,
                   input  in_ready, vec_valid, out_vec, done);
   modport slave  (input  in_valid, in_pixel, vec_ack,
                   output in_ready, vec_valid, out_vec, done);
endinterface

// File: rtl/max2_relu.sv
// Combinational signed max of two words, optionally clamped at zero.
module max2_relu #(
   parameter int DATA_W = 32
) (
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic                     relu_en,
   output logic signed [DATA_W-1:0] y
);
   function automatic logic signed [DATA_W-1:0] smax_w(input logic signed [DATA_W-1:0] x0,
                                                       input logic signed [DATA_W-1:0] x1);
      return (x0 > x1) ? x0 : x1;
   endfunction

   function automatic logic signed [DATA_W-1:0] relu_w(input logic signed [DATA_W-1:0] x);
      return x[DATA_W-1] ? '0 : x;
   endfunction

   assign y = relu_en ? relu_w(smax_w(a, b)) : smax_w(a, b);
endmodule

// File: rtl/maxpool_flatten.sv
// Streaming 2x2/stride-2 signed max-pool + ReLU; assembles the pooled map as a
// flat vector and holds it until the FC stage acknowledges.
module maxpool_flatten #(
   parameter int DATA_W = cnn_pkg::DATA_W,
   parameter int IN_H   = 6,
   parameter int IN_W   = 6
) (
   input logic              clk,
   input logic              rst,
   maxpool_flatten_if.slave bus
);
   import cnn_pkg::*;

   localparam int OUT_N  = (IN_H/2)*(IN_W/2);
   localparam int HALF_W = IN_W/2;
   localparam int RW     = $clog2(IN_H);
   localparam int CW     = $clog2(IN_W);
   localparam int HW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;

   if ((IN_H % 2) != 0 || (IN_W % 2) != 0 || IN_H < 2 || IN_W < 2) begin : g_bad_dims
      $error("maxpool_flatten: IN_H and IN_W must be even and non-zero");
   end

   state_t                   state_q, state_d;
   logic [RW-1:0]            row_q;
   logic [CW-1:0]            col_q;
   logic [HW-1:0]            cidx;
   int                       oidx;
   logic                     vld_p0, last_p0, col_end, row_end, done_q;
   logic signed [DATA_W-1:0] pix_p0, hold_q, max_a, max_y, relu_y;
   logic signed [DATA_W-1:0] rowbuf_q [HALF_W];
   logic [OUT_N*DATA_W-1:0]  out_q;

   assign bus.in_ready  = (state_q == FILL) && !rst;
   assign bus.vec_valid = (state_q == HOLD);
   assign bus.done      = done_q;
   assign bus.out_vec   = out_q;

   assign vld_p0  = bus.in_valid && bus.in_ready;
   assign pix_p0  = bus.in_pixel;
   assign col_end = (col_q == CW'(IN_W-1));
   assign row_end = (row_q == RW'(IN_H-1));
   assign last_p0 = vld_p0 && col_end && row_end;
   assign cidx    = HW'(col_q >> 1);
   assign oidx    = int'(row_q >> 1) * HALF_W + int'(cidx);

   // Odd rows fold the column-pair max saved from the even row above.
   assign max_a = row_q[0] ? rowbuf_q[cidx] : hold_q;

   max2_relu #(.DATA_W(DATA_W)) u_max (
      .a(max_a), .b(pix_p0), .relu_en(1'b0), .y(max_y)
   );

   max2_relu #(.DATA_W(DATA_W)) u_relu (
      .a(hold_q), .b(pix_p0), .relu_en(1'b1), .y(relu_y)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (last_p0) state_d = HOLD;
         HOLD:    if (bus.vec_ack) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FILL;
         row_q   <= '0;
         col_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= last_p0;
         if (vld_p0) begin
            if (col_end) begin
               col_q <= '0;
               row_q <= row_end ? '0 : row_q + 1'b1;
            end else begin
               col_q <= col_q + 1'b1;
            end
         end
      end
   end

   // Stage p0 -> registered window state; pooled entry lands one cycle after its last pixel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q <= '0;
         for (int i = 0; i < HALF_W; i++) rowbuf_q[i] <= '0;
         out_q  <= '0;
      end else if (vld_p0) begin
         case ({row_q[0], col_q[0]})
            2'b00:   hold_q         <= pix_p0;
            2'b01:   rowbuf_q[cidx] <= max_y;
            2'b10:   hold_q         <= max_y;
            default: out_q[oidx*DATA_W +: DATA_W] <= relu_y;
         endcase
      end
   end
endmodule
